serial_mod_detector: RTL

Parametrised serial divisibility detector. It tracks the remainder of a bit-serial binary number modulo DIVISOR and flags when the number received so far is divisible. It is the general successor to the fixed divide-by-N checker, and adds arbitrary divisor, MSB-first or LSB-first bit order, valid-qualified input, frame restart, remainder readout and frame-length tracking. It sits on serial datapaths between a bit deserialiser and frame-level checking logic.

---
 rtl/serial_mod_detector.sv | 82 ++++++++
 1 files changed

// File: rtl/serial_mod_detector.sv
// Bit-serial divisibility detector: tracks the running value mod DIVISOR in MSB-first
// or LSB-first order, with frame restart, remainder readout and frame-length tracking.
module serial_mod_detector #(
  parameter  int DIVISOR = 5,
  parameter  int MAXLEN  = 32,
  localparam int RW      = $clog2(DIVISOR),
  localparam int LW      = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          din,
  input  logic          lsb_first,
  output logic [RW-1:0] rem_out,
  output logic          dout,
  output logic [LW-1:0] frame_len,
  output logic          len_ovf
);

  if (DIVISOR < 2 || DIVISOR > 255 || MAXLEN < 1) begin : g_bad_param
    $error("serial_mod_detector: DIVISOR must be 2..255 and MAXLEN >= 1");
  end

  localparam logic [RW:0]   DIV    = (RW+1)'(DIVISOR);
  localparam logic [RW-1:0] W_INIT = RW'(2 % DIVISOR);
  localparam logic [LW-1:0] MAXL   = LW'(MAXLEN);

  logic [RW-1:0] rem, w;
  logic          mode, started;
  logic [LW-1:0] len;
  logic          ovf;

  // Operands are both < DIVISOR, so one conditional subtract fully reduces the sum.
  function automatic logic [RW-1:0] mod_red(input logic [RW:0] s);
    return (s >= DIV) ? RW'(s - DIV) : s[RW-1:0];
  endfunction

  logic [RW:0] msb_sum, lsb_sum, w_dbl;
  logic        frame_start;

  always_comb begin
    msb_sum     = {rem, din};
    lsb_sum     = {1'b0, rem} + (din ? {1'b0, w} : '0);
    w_dbl       = {w, 1'b0};
    frame_start = in_valid & (in_sof | ~started);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem     <= '0;
      w       <= RW'(1);
      mode    <= 1'b0;
      started <= 1'b0;
      len     <= '0;
      ovf     <= 1'b0;
    end else if (frame_start) begin
      rem     <= RW'(din);
      w       <= W_INIT;
      mode    <= in_sof ? lsb_first : 1'b0;
      started <= 1'b1;
      len     <= LW'(1);
      ovf     <= 1'b0;
    end else if (in_valid) begin
      if (mode) begin
        rem <= mod_red(lsb_sum);
        w   <= mod_red(w_dbl);
      end else begin
        rem <= mod_red(msb_sum);
      end
      // Length saturates; the remainder keeps tracking past the limit.
      if (len == MAXL) ovf <= 1'b1;
      else             len <= len + LW'(1);
    end
  end

  assign rem_out   = rem;
  assign dout      = started & (rem == '0);
  assign frame_len = len;
  assign len_ovf   = ovf;

endmodule
